// File: rtl/qpsk_demod.sv
// QPSK demodulator: mixes the received samples with local sine/cosine, integrates over one
// symbol, takes sign decisions and serializes the two decided bits (sine branch first).
module qpsk_demod #(
   parameter int unsigned SPS = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               en,
   input  logic signed [15:0] sig_in,
   input  logic signed [15:0] sine_in,
   input  logic signed [15:0] cosine_in,
   input  logic               sym_sync,
   output logic               elojel_sin,
   output logic               elojel_cos,
   output logic               sym_valid,
   output logic               adat_ki,
   output logic               bit_valid
);

   localparam int unsigned CntW = $clog2(SPS);
   localparam logic [CntW-1:0] CntMax = CntW'(SPS - 1);

   typedef enum logic [0:0] {SerIdle, SerCos} ser_e;

   logic signed [31:0] prod_i_q, prod_q_q;
   logic               p_vld;
   logic signed [39:0] acc_i_q, acc_q_q;
   logic signed [39:0] ext_i, ext_q, sum_i, sum_q;
   logic [CntW-1:0]    cnt_q;
   ser_e               ser_q, ser_d;
   logic               adat_d, bit_valid_d;

   // Stage 1: full-precision mixer products
   always_ff @(posedge clk) begin
      if (!rst) begin
         prod_i_q <= '0;
         prod_q_q <= '0;
         p_vld    <= 1'b0;
      end else begin
         p_vld <= en;
         if (en) begin
            prod_i_q <= 32'(sig_in) * 32'(sine_in);
            prod_q_q <= 32'(sig_in) * 32'(cosine_in);
         end
      end
   end

   always_comb begin
      ext_i = 40'(prod_i_q);
      ext_q = 40'(prod_q_q);
      sum_i = acc_i_q + ext_i;
      sum_q = acc_q_q + ext_q;
   end

   // Stage 2: integrate-and-dump; sym_sync drops the in-flight product
   always_ff @(posedge clk) begin
      if (!rst) begin
         cnt_q      <= '0;
         acc_i_q    <= '0;
         acc_q_q    <= '0;
         elojel_sin <= 1'b0;
         elojel_cos <= 1'b0;
         sym_valid  <= 1'b0;
      end else begin
         sym_valid <= 1'b0;
         if (sym_sync) begin
            cnt_q   <= '0;
            acc_i_q <= '0;
            acc_q_q <= '0;
         end else if (p_vld) begin
            acc_i_q <= (cnt_q == '0) ? ext_i : sum_i;
            acc_q_q <= (cnt_q == '0) ? ext_q : sum_q;
            if (cnt_q == CntMax) begin
               cnt_q      <= '0;
               elojel_sin <= ~sum_i[39];
               elojel_cos <= ~sum_q[39];
               sym_valid  <= 1'b1;
            end else begin
               cnt_q <= cnt_q + 1'b1;
            end
         end
      end
   end

   always_comb begin
      ser_d       = ser_q;
      adat_d      = adat_ki;
      bit_valid_d = 1'b0;
      unique case (ser_q)
         SerIdle: begin
            if (sym_valid) begin
               adat_d      = elojel_sin;
               bit_valid_d = 1'b1;
               ser_d       = SerCos;
            end
         end
         SerCos: begin
            adat_d      = elojel_cos;
            bit_valid_d = 1'b1;
            ser_d       = SerIdle;
         end
         default: ser_d = SerIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         ser_q     <= SerIdle;
         adat_ki   <= 1'b0;
         bit_valid <= 1'b0;
      end else begin
         ser_q     <= ser_d;
         adat_ki   <= adat_d;
         bit_valid <= bit_valid_d;
      end
   end

endmodule

// File: tb/tb_qpsk_demod.sv
// Scoreboard bench for qpsk_demod: a behavioural integrator model queues expected symbols and
// serial bits with their due cycle; a negedge monitor pops and compares.
module tb_qpsk_demod;

   localparam int unsigned Sps = 4;

   logic               clk = 1'b0;
   logic               rst;
   logic               en, sym_sync;
   logic signed [15:0] sig_in, sine_in, cosine_in;
   logic               elojel_sin, elojel_cos, sym_valid, adat_ki, bit_valid;

   logic               en_b;
   logic signed [15:0] sig_b;
   logic               esin_b, ecos_b, sv_b, adat_b, bv_b;

   qpsk_demod #(.SPS(Sps)) dut (
      .clk(clk), .rst(rst), .en(en), .sig_in(sig_in), .sine_in(sine_in),
      .cosine_in(cosine_in), .sym_sync(sym_sync), .elojel_sin(elojel_sin),
      .elojel_cos(elojel_cos), .sym_valid(sym_valid), .adat_ki(adat_ki), .bit_valid(bit_valid)
   );

   qpsk_demod #(.SPS(256)) dut_big (
      .clk(clk), .rst(rst), .en(en_b), .sig_in(sig_b), .sine_in(sig_b),
      .cosine_in(sig_b), .sym_sync(1'b0), .elojel_sin(esin_b),
      .elojel_cos(ecos_b), .sym_valid(sv_b), .adat_ki(adat_b), .bit_valid(bv_b)
   );

   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   task automatic check_eq(input string tag, input longint got, input longint exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   typedef struct {int unsigned cyc; logic s; logic c;} sym_t;
   typedef struct {int unsigned cyc; logic b;} bit_t;
   sym_t sym_q[$];
   bit_t bit_q[$];
   logic last_bit = 1'b0;
   logic mon_on = 1'b0;

   // Behavioural reference integrator
   longint m_ai, m_aq;
   int     m_cnt;

   task automatic model_clear();
      m_ai = 0; m_aq = 0; m_cnt = 0;
   endtask

   task automatic send(input logic signed [15:0] s, input logic signed [15:0] sn,
                       input logic signed [15:0] cs, input logic e, input logic sy);
      sym_t x;
      sig_in = s; sine_in = sn; cosine_in = cs; en = e; sym_sync = sy;
      if (sy) model_clear();
      if (e) begin
         m_ai += longint'(s) * longint'(sn);
         m_aq += longint'(s) * longint'(cs);
         m_cnt++;
         if (m_cnt == Sps) begin
            x.cyc = cyc + 2; x.s = (m_ai >= 0); x.c = (m_aq >= 0);
            sym_q.push_back(x);
            model_clear();
         end
      end
      @(posedge clk); #1;
      en = 1'b0; sym_sync = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) send(16'sd0, 16'sd0, 16'sd0, 1'b0, 1'b0);
   endtask

   always @(negedge clk) begin
      if (mon_on) begin
         while (sym_q.size() > 0 && sym_q[0].cyc < cyc) begin
            check_eq("sym_missed", 0, 1);
            void'(sym_q.pop_front());
         end
         if (sym_q.size() > 0 && sym_q[0].cyc == cyc) begin
            sym_t x;
            bit_t b;
            x = sym_q.pop_front();
            check_eq("sym_valid", sym_valid, 1);
            check_eq("elojel_sin", elojel_sin, x.s);
            check_eq("elojel_cos", elojel_cos, x.c);
            b.cyc = cyc + 1; b.b = x.s; bit_q.push_back(b);
            b.cyc = cyc + 2; b.b = x.c; bit_q.push_back(b);
         end else begin
            check_eq("sym_valid_idle", sym_valid, 0);
         end
         if (bit_q.size() > 0 && bit_q[0].cyc == cyc) begin
            bit_t b;
            b = bit_q.pop_front();
            check_eq("bit_valid", bit_valid, 1);
            check_eq("adat_ki", adat_ki, b.b);
            last_bit = b.b;
         end else begin
            check_eq("bit_valid_idle", bit_valid, 0);
            check_eq("adat_hold", adat_ki, last_bit);
         end
      end
   end

   task automatic do_reset();
      rst = 1'b0; en = 1'b1; sym_sync = 1'b1;
      sig_in = 16'sd12345; sine_in = 16'sd321; cosine_in = -16'sd999;
      @(posedge clk); #1;
      rst = 1'b1; en = 1'b0; sym_sync = 1'b0;
      model_clear();
      sym_q.delete(); bit_q.delete(); last_bit = 1'b0;
      check_eq("rst_sin", elojel_sin, 0);
      check_eq("rst_cos", elojel_cos, 0);
      check_eq("rst_sym_valid", sym_valid, 0);
      check_eq("rst_adat", adat_ki, 0);
      check_eq("rst_bit_valid", bit_valid, 0);
   endtask

   initial begin
      bit found;
      logic fs, fc;
      rst = 1'b0; en = 1'b0; sym_sync = 1'b0;
      sig_in = '0; sine_in = '0; cosine_in = '0; en_b = 1'b0; sig_b = '0;
      model_clear();
      repeat (2) @(posedge clk);
      #1;
      do_reset();
      check_eq("rst_big_sv", sv_b, 0);
      check_eq("rst_big_bv", bv_b, 0);
      mon_on = 1'b1;

      // Zero sine branch decides 1; positive cosine
      for (int i = 0; i < 4; i++) send(16'sd16384, 16'sd0, 16'sd16384, 1'b1, 1'b0);
      idle(4);

      // Negative sine correlation, zero cosine
      for (int i = 0; i < 4; i++)
         send((i % 2 == 0) ? -16'sd20000 : 16'sd20000,
              (i % 2 == 0) ? 16'sd20000 : -16'sd20000, 16'sd0, 1'b1, 1'b0);
      idle(4);

      // en every third cycle
      for (int i = 0; i < 4; i++) begin
         send(16'sd3000, 16'sd2000, -16'sd2000, 1'b1, 1'b0);
         send(-16'sd30000, 16'sd30000, 16'sd30000, 1'b0, 1'b0);
         send(-16'sd30000, 16'sd30000, 16'sd30000, 1'b0, 1'b0);
      end
      idle(4);

      // Realignment: pre-sync samples would flip the sine decision
      send(16'sd20000, -16'sd20000, -16'sd20000, 1'b1, 1'b0);
      send(16'sd20000, -16'sd20000, -16'sd20000, 1'b1, 1'b0);
      for (int i = 0; i < 4; i++) send(16'sd100, 16'sd100, -16'sd100, 1'b1, (i == 0));
      idle(4);

      // Reset after 3 of 4 samples
      for (int i = 0; i < 3; i++) send(16'sd5000, 16'sd5000, 16'sd5000, 1'b1, 1'b0);
      do_reset();
      for (int i = 0; i < 4; i++) send(-16'sd700, 16'sd800, -16'sd900, 1'b1, 1'b0);
      idle(4);

      // Random samples with random gaps
      for (int i = 0; i < 60; i++)
         send(16'($urandom), 16'($urandom), 16'($urandom), ($urandom_range(0, 2) != 0), 1'b0);
      idle(2);
      while (m_cnt != 0) send(16'($urandom), 16'($urandom), 16'($urandom), 1'b1, 1'b0);
      idle(6);
      check_eq("sym_q_empty", sym_q.size(), 0);
      check_eq("bit_q_empty", bit_q.size(), 0);

      // SPS=256 full-scale: sum reaches +2^38 without wrap
      en_b = 1'b1; sig_b = -16'sd32768;
      repeat (256) @(posedge clk);
      #1;
      en_b = 1'b0;
      found = 1'b0; fs = 1'b0; fc = 1'b0;
      for (int i = 0; i < 6 && !found; i++) begin
         if (sv_b) begin found = 1'b1; fs = esin_b; fc = ecos_b; end
         @(posedge clk); #1;
      end
      check_eq("big_sym_valid", found, 1);
      check_eq("big_sin", fs, 1);
      check_eq("big_cos", fc, 1);

      mon_on = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
